uart_rx: RTL
============

# uart_rx

Parametrized UART receiver that samples the asynchronous serial line, reconstructs one frame (start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits) and presents the word with a one-cycle valid strobe. It is the receive-side stage behind the `rxif` modport of `uart_interface`: it drives `data`, `valid` and `ready`, and it consumes `signal`. Two status flags report framing and parity errors.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9).
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- Derived: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer, truncating), must be ≥ 4. HALF_BIT = CLKS_PER_BIT / 2.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- signal  input  1  serial RX line; idles high; asynchronous to clk.
- data  output  DATA_WIDTH  last received word; holds until the next valid.
- valid  output  1  one-cycle pulse when a frame completes.
- ready  output  1  high while in IDLE, meaning no frame is in progress.
- frame_err  output  1  qualified by valid: a stop bit was sampled 0.
- parity_err  output  1  qualified by valid: parity mismatch; always 0 when PARITY = 0.

## Operation
- `signal` passes through a 2-flop synchronizer before any use. Both flops reset to 1.
- One baud counter, width clog2(CLKS_PER_BIT). One bit index counter. One shift register.
- FSM states and transitions:
  - IDLE: ready = 1. On a synchronized 0, load the counter and go to START.
  - START: after HALF_BIT cycles, sample the line. If 0, go to DATA. If 1, treat it as a glitch and return to IDLE. Nothing is reported.
  - DATA: sample every CLKS_PER_BIT cycles. Shift in LSB first. After DATA_WIDTH samples, go to PARITY if PARITY ≠ 0, otherwise go to STOP.
  - PARITY: take one sample. Compare it with the XOR of the data bits (even) or its inverse (odd).
  - STOP: take STOP_BITS samples, CLKS_PER_BIT apart. Any 0 sets the internal frame flag. After the last sample:
    - Update data.
    - Pulse valid for one cycle.
    - Drive frame_err and parity_err in that same cycle.
    - If the frame flag is clear, go to IDLE. If it is set, go to BREAK.
  - BREAK: wait until the synchronized line is 1, then go to IDLE. This prevents a held-low line (break) from being re-read as a start bit.
- Error handling:
  - Frames with errors still update data and pulse valid.
  - The error flags are cleared in the cycle after valid.
- No backpressure: valid is not gated by any consumer signal. A consumer that misses the pulse loses the word. data remains readable until the next valid.
- Reset mid-frame: the block returns to IDLE immediately. The partial frame is discarded and no valid is produced.

## Timing
- Reset values: data = 0, valid = 0, ready = 1, frame_err = 0, parity_err = 0. FSM = IDLE, synchronizer = 1.
- Synchronizer latency: 2 clk.
- Start edge to IDLE exit: the START transition occurs 2 clk after the line falls (± 1 clk of asynchrony).
- Sample points: the start bit is sampled HALF_BIT cycles after entering START. Each later bit is sampled exactly CLKS_PER_BIT cycles after the previous sample.
- Frame latency: valid rises 1 clk after the last stop-bit sample. With B = 1 + DATA_WIDTH + (PARITY ≠ 0) + STOP_BITS, valid asserts about (B − 1)·CLKS_PER_BIT + HALF_BIT + 3 clk after the start falling edge.
- ready falls in the cycle START is entered. It rises in the cycle IDLE is re-entered, which is the same cycle valid is high when there is no frame error.
- Back-to-back frames: a start bit that begins immediately after the last stop bit's mid-point is caught. IDLE is reached by the end of the first half of the stop bit.

## Test plan
- CLK_FREQ = 1_600_000, BAUD_RATE = 100_000 (CLKS_PER_BIT = 16), 8N1, send 0xA5 → exactly one valid pulse, data = 0xA5, both error flags 0, ready = 0 during the frame.
- Same config, send 0x00 then 0xFF back-to-back with zero idle between them → two valid pulses 160 clk apart, data = 0x00 then 0xFF.
- PARITY = 2 (odd), send 0x03 with parity bit 1 → parity_err = 0. Resend with parity bit 0 → data = 0x03, parity_err = 1 for one cycle only.
- Stop bit driven 0, then line held low for 40 clk → valid with frame_err = 1, then FSM stays in BREAK (ready = 0) until the line goes high, and no spurious second frame is produced.
- Low glitch of 5 clk on an idle line → no valid, ready returns to 1 within HALF_BIT + 3 clk.
- rst_n asserted midway through data bit 4 → all outputs return to reset values immediately, no valid. A following clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Purpose: UART receiver. Synchronizes the asynchronous serial line, finds the
// start bit, samples every bit at its mid-point and reassembles one frame
// (start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits).
// The received word is presented with a one-cycle valid strobe, together with
// framing and parity error flags that are only meaningful while valid is high.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   signal     in   serial RX line, idles high, asynchronous to clk
//   data       out  last received word, held until the next valid
//   valid      out  one-cycle pulse when a frame completes
//   ready      out  high while idle (no frame in progress)
//   frame_err  out  with valid: a stop bit was sampled low
//   parity_err out  with valid: parity mismatch (always 0 when PARITY = 0)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  ready,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

    // Counter reload values: the counter counts down and a sample is taken
    // in the cycle it reads zero, so reloading N-1 spaces samples N apart.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PARITY    = (PARITY == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // Two-flop synchronizer; both flops reset to the idle line level.
    logic sync1_q, sync2_q;
    logic rx;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_bad_q, par_bad_d;
    logic                  frm_bad_q, frm_bad_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_q, perr_d;
    logic                  tick;
    logic                  frm_now;

    assign rx   = sync2_q;
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= signal;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        // Error flags are only driven in the valid cycle, so they clear
        // automatically in the following cycle.
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        frm_now   = frm_bad_q | ~rx;

        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end

            S_START: begin
                if (tick) begin
                    if (!rx) begin
                        state_d   = S_DATA;
                        cnt_d     = CNT_FULL;
                        idx_d     = '0;
                        par_bad_d = 1'b0;
                        frm_bad_d = 1'b0;
                    end else begin
                        // Line went back high before mid-bit: a glitch.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (tick) begin
                    // Bits arrive LSB first: enter at the top, shift down.
                    shift_d = {rx, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == IDX_DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (tick) begin
                    // Mismatch when sampled bit differs from the XOR of the
                    // data (even) or its inverse (odd).
                    par_bad_d = rx ^ (^shift_q) ^ ODD_PARITY;
                    cnt_d     = CNT_FULL;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_STOP: begin
                if (tick) begin
                    if (idx_q == IDX_STOP_LAST) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = frm_now;
                        perr_d  = par_bad_q;
                        // A low stop bit may be the start of a break; wait
                        // for the line to recover before hunting again.
                        state_d = frm_now ? S_BREAK : S_IDLE;
                    end else begin
                        frm_bad_d = frm_now;
                        idx_d     = idx_q + IDX_W'(1);
                        cnt_d     = CNT_FULL;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_BREAK: begin
                if (rx) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            frm_bad_q <= frm_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign ready      = (state_q == S_IDLE);
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule
